// File: rtl/ov7670_cfg_seq.sv
// Purpose: OV7670 bring-up sequencer; holds the camera in reset, then streams a mode-dependent register table to an SCCB master.
// Latency: table word appears on addr/data_wr one cycle after its index changes; start_tx is decoded in the accepting WAIT_RDY cycle.
// Backpressure: each write waits for sccb_ready, and the index only advances on an acknowledged sccb_done.
module ov7670_cfg_seq #(
  parameter int unsigned C_RST_CYC   = 30000000,
  parameter int unsigned C_WAIT_CYC  = 30000000,
  parameter int unsigned C_GAP_CYC   = 1000,
  parameter int unsigned C_XCLK_DIV  = 4,
  parameter int unsigned C_MAX_RETRY = 3,
  parameter logic [6:0]  C_ID        = 7'h21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       resend,
  input  logic       sccb_ready,
  input  logic       sccb_done,
  input  logic       sccb_nack,
  output logic       start_tx,
  output logic [6:0] id,
  output logic [7:0] addr,
  output logic [7:0] data_wr,
  output logic       done,
  output logic       error,
  output logic       busy,
  output logic [3:0] cnt_reg,
  output logic [1:0] retry_cnt,
  output logic       ov7670_rst_n,
  output logic       ov7670_pwdn,
  output logic       ov7670_clk
);

  localparam int XW = (C_XCLK_DIV > 2) ? $clog2(C_XCLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_RSTCAM,
    S_WAIT_RSTCAM,
    S_LOAD,
    S_WAIT_RDY,
    S_WAIT_DONE,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  logic [31:0]   dly;
  logic [1:0]    mode_q;
  logic          resend_pend;
  logic          restart;
  logic [XW-1:0] xcnt;
  logic [XW-1:0] xcnt_nxt;

  // Register table: eight common entries, seven per-mode entries, FFFF terminator.
  function automatic logic [15:0] rom_word(input logic [1:0] m, input logic [3:0] i);
    logic [15:0] w;
    w = 16'hFFFF;
    if (i[3] == 1'b0) begin
      case (i[2:0])
        3'd0:    w = 16'h1280;
        3'd1:    w = 16'h1280;
        3'd2:    w = 16'h1204;
        3'd3:    w = 16'h40F0;
        3'd4:    w = 16'h8C02;
        3'd5:    w = 16'h1181;
        3'd6:    w = 16'h0F43;
        default: w = 16'h1520;
      endcase
    end else if (i != 4'd15) begin
      case ({m, i[2:0]})
        5'b00_000: w = 16'h0C04;
        5'b00_001: w = 16'h3E1B;
        5'b00_010: w = 16'h703A;
        5'b00_011: w = 16'h71B5;
        5'b00_100: w = 16'h7233;
        5'b00_101: w = 16'h73F3;
        5'b01_000: w = 16'h0C04;
        5'b01_001: w = 16'h3E1A;
        5'b01_010: w = 16'h703A;
        5'b01_011: w = 16'h7135;
        5'b01_100: w = 16'h7222;
        5'b01_101: w = 16'h73F2;
        5'b10_000: w = 16'h0C04;
        5'b10_001: w = 16'h3E19;
        5'b10_010: w = 16'h703A;
        5'b10_011: w = 16'h7135;
        5'b10_100: w = 16'h7211;
        5'b10_101: w = 16'h73F1;
        5'b11_000: w = 16'h0C00;
        5'b11_001: w = 16'h3E00;
        5'b11_010: w = 16'h703A;
        5'b11_011: w = 16'h7135;
        5'b11_100: w = 16'h7211;
        5'b11_101: w = 16'h73F0;
        default:   w = 16'hA202;
      endcase
    end
    return w;
  endfunction

  assign id          = C_ID;
  assign ov7670_pwdn = 1'b0;

  // A write is launched in the very WAIT_RDY cycle that sees the master idle; a pending restart suppresses it.
  assign start_tx = !rst && (state == S_WAIT_RDY) && (addr != 8'hFF) && sccb_ready && !resend;

  // Any route back to RSTCAM: user resend, deferred resend after an in-flight write, or a mode change once finished.
  assign restart = (resend && (state != S_WAIT_DONE)) ||
                   ((state == S_WAIT_DONE) && sccb_done && (resend_pend || resend)) ||
                   (((state == S_DONE) || (state == S_ERROR)) && (mode != mode_q));

  assign xcnt_nxt = (xcnt == XW'(C_XCLK_DIV - 1)) ? '0 : xcnt + XW'(1);

  // XCLK divider: free-running, high for the upper half of the count range.
  always_ff @(posedge clk) begin
    if (rst) begin
      xcnt       <= '0;
      ov7670_clk <= 1'b0;
    end else begin
      xcnt       <= xcnt_nxt;
      ov7670_clk <= (xcnt_nxt >= XW'(C_XCLK_DIV / 2));
    end
  end

  // Registered table lookup; holds the failing entry in ERROR because the index is frozen there.
  always_ff @(posedge clk) begin
    if (rst) begin
      {addr, data_wr} <= 16'h1280;
    end else begin
      {addr, data_wr} <= rom_word(mode_q, cnt_reg);
    end
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RSTCAM;
      dly          <= '0;
      mode_q       <= 2'd0;
      resend_pend  <= 1'b0;
      cnt_reg      <= 4'd0;
      retry_cnt    <= 2'd0;
      done         <= 1'b0;
      error        <= 1'b0;
      busy         <= 1'b1;
      ov7670_rst_n <= 1'b0;
    end else if (restart) begin
      state        <= S_RSTCAM;
      dly          <= '0;
      resend_pend  <= 1'b0;
      cnt_reg      <= 4'd0;
      retry_cnt    <= 2'd0;
      done         <= 1'b0;
      error        <= 1'b0;
      busy         <= 1'b1;
      ov7670_rst_n <= 1'b0;
    end else begin
      case (state)
        S_RSTCAM: begin
          ov7670_rst_n <= 1'b0;
          mode_q       <= mode;
          cnt_reg      <= 4'd0;
          retry_cnt    <= 2'd0;
          resend_pend  <= 1'b0;
          if (dly == C_RST_CYC - 1) begin
            state        <= S_WAIT_RSTCAM;
            dly          <= '0;
            ov7670_rst_n <= 1'b1;
          end else begin
            dly <= dly + 32'd1;
          end
        end
        S_WAIT_RSTCAM: begin
          if (dly == C_WAIT_CYC - 1) begin
            state <= S_LOAD;
            dly   <= '0;
          end else begin
            dly <= dly + 32'd1;
          end
        end
        S_LOAD: begin
          state <= S_WAIT_RDY;
          dly   <= '0;
        end
        S_WAIT_RDY: begin
          dly <= '0;
          if (addr == 8'hFF) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (sccb_ready) begin
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          dly <= '0;
          if (resend) begin
            resend_pend <= 1'b1;
          end
          if (sccb_done) begin
            if (!sccb_nack) begin
              cnt_reg   <= cnt_reg + 4'd1;
              retry_cnt <= 2'd0;
              state     <= S_GAP;
            end else if (retry_cnt < 2'(C_MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 2'd1;
              state     <= S_GAP;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (dly == C_GAP_CYC - 1) begin
            state <= S_LOAD;
            dly   <= '0;
          end else begin
            dly <= dly + 32'd1;
          end
        end
        S_DONE: begin
          dly  <= '0;
          done <= 1'b1;
          busy <= 1'b0;
        end
        S_ERROR: begin
          dly   <= '0;
          error <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_RSTCAM;
          dly   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/ov7670_cfg_seq.md
Name: ov7670_cfg_seq

Overview:
Parametrised camera configuration sequencer for the OV7670. It holds the camera in reset, waits for power-up, and then streams a resolution-dependent register table to the SCCB master. It also generates XCLK and drives PWDN. Compared with the single-table controller, it adds four selectable resolution modes, NACK retry with an error state, automatic re-configuration on mode change, and parametrised timing. It sits between the top-level control inputs and the SCCB master.

Parameters:
C_RST_CYC, 30000000, clk cycles the camera is held in reset (300 ms at 100 MHz).
C_WAIT_CYC, 30000000, clk cycles to wait after reset release before the first write.
C_GAP_CYC, 1000, idle clk cycles after each SCCB transaction (success or NACK).
C_XCLK_DIV, 4, even divider, >=2, from clk to ov7670_clk.
C_MAX_RETRY, 3, retries per register after a NACK before declaring an error.
C_ID, 7'h21, SCCB slave id.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
mode  in  2  resolution: 0=80x60, 1=QQVGA 160x120, 2=QVGA 320x240, 3=VGA 640x480
resend  in  1  request to restart the full sequence
sccb_ready  in  1  SCCB master idle
sccb_done  in  1  one-cycle pulse, end of transaction
sccb_nack  in  1  valid with sccb_done; 1 = slave did not acknowledge
start_tx  out  1  one-cycle pulse that starts an SCCB write
id  out  7  constant C_ID
addr  out  8  register address
data_wr  out  8  register data
done  out  1  table completed successfully
error  out  1  retries exhausted
busy  out  1  sequence in progress (not DONE and not ERROR)
cnt_reg  out  4  current table index
retry_cnt  out  2  retries used on the current index
ov7670_rst_n  out  1  camera reset, active low
ov7670_pwdn  out  1  tied to 0
ov7670_clk  out  1  camera XCLK

Behaviour:
- Reset (synchronous, rst=1):
  - FSM goes to RSTCAM.
  - cnt_reg=0, retry_cnt=0, start_tx=0, done=0, error=0, busy=1.
  - ov7670_rst_n=0, ov7670_clk=0, XCLK divider count=0.
  - addr/data register loads 16'h1280.
- XCLK:
  - Free-running counter 0..C_XCLK_DIV-1.
  - ov7670_clk=1 when count >= C_XCLK_DIV/2, giving a 50% duty cycle.
  - Unaffected by resend.
- Table ROM, indexed by {latched mode, cnt_reg}:
  - Indices 0-7, common to all modes: 1280, 1280, 1204, 40F0, 8C02, 1181, 0F43, 1520.
  - Indices 8-14, mode 0: 0C04, 3E1B, 703A, 71B5, 7233, 73F3, A202.
  - Indices 8-14, mode 1: 0C04, 3E1A, 703A, 7135, 7222, 73F2, A202.
  - Indices 8-14, mode 2: 0C04, 3E19, 703A, 7135, 7211, 73F1, A202.
  - Indices 8-14, mode 3: 0C00, 3E00, 703A, 7135, 7211, 73F0, A202.
  - Index 15: FFFF, the terminator.
  - ROM output is registered into {addr, data_wr}; one cycle latency.
- FSM states:
  - RSTCAM: ov7670_rst_n=0; latch mode into mode_q; cnt_reg=0; retry_cnt=0; count C_RST_CYC cycles -> WAIT_RSTCAM.
  - WAIT_RSTCAM: ov7670_rst_n=1; count C_WAIT_CYC cycles -> LOAD.
  - LOAD: one cycle so the ROM register updates -> WAIT_RDY.
  - WAIT_RDY:
    - If addr==8'hFF -> DONE.
    - Else if sccb_ready: start_tx=1 for exactly this cycle -> WAIT_DONE.
  - WAIT_DONE, on sccb_done:
    - nack=0: cnt_reg+1, retry_cnt=0 -> GAP.
    - nack=1 and retry_cnt<C_MAX_RETRY: retry_cnt+1, cnt_reg held -> GAP.
    - nack=1 and retry_cnt==C_MAX_RETRY: -> ERROR.
  - GAP: count C_GAP_CYC cycles -> LOAD.
  - DONE: done=1, busy=0.
  - ERROR: error=1, busy=0; addr/cnt_reg hold the failing entry.
- Delay counter: shared by all timed states. It clears on every state change. A timed state exits in the cycle the count reaches its limit-1, so the state lasts exactly N cycles.
- Restart conditions:
  - resend=1 in any state other than WAIT_DONE -> RSTCAM next cycle.
  - resend=1 during WAIT_DONE sets a pending flag. After sccb_done is received the FSM goes to RSTCAM, ignoring the nack result. The pending flag clears on RSTCAM entry.
  - In DONE or ERROR, mode != mode_q -> RSTCAM (automatic re-configuration).
  - In all other states a mode change is ignored until the next restart.
  - done and error clear in the cycle RSTCAM is entered.
- sccb_done outside WAIT_DONE is ignored.
- start_tx is never asserted while addr==FF or outside WAIT_RDY.

Test Plan:
- Settings for all scenarios: C_RST_CYC=8, C_WAIT_CYC=8, C_GAP_CYC=4, C_MAX_RETRY=3. The SCCB model always acks and raises sccb_done 10 cycles after start_tx.
- Normal run, mode=0 -> ov7670_rst_n low exactly 8 cycles; 15 start_tx pulses with addr/data sequence 1280, 1280, 1204 … A202; then done=1, busy=0, cnt_reg=15.
- Mode 3 run -> index 8 = 0C00, index 13 = 73F0. Changing mode to 1 while done=1 -> done drops next cycle, ov7670_rst_n=0, second pass shows 3E1A at index 9.
- NACK on index 4 three times, then ack -> start_tx issued 4 times with 8C02, retry_cnt sequence 1, 2, 3, 0; sequence completes with done=1.
- NACK on index 5 always -> exactly 4 transmissions of 1181; then error=1, cnt_reg=5, no further start_tx. resend=1 -> RSTCAM, error=0.
- resend pulse while in WAIT_DONE at index 6 -> no new start_tx before sccb_done; RSTCAM entered the cycle after sccb_done; full sequence restarts from index 0.
- rst asserted mid-sequence (index 10) -> next cycle cnt_reg=0, ov7670_rst_n=0, start_tx=0, ov7670_clk=0. XCLK period is 4 clk with 2 high / 2 low.
